seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux_pkg.sv | 17 +
 rtl/seg_tick_counter.sv | 42 ++++
 rtl/seg_scan_mux.sv | 122 ++++++++++++
 tb/tb_seg_scan_mux.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/seg_scan_mux_pkg.sv
// rtl/seg_scan_mux_pkg.sv - shared types and constants for the segment scan multiplexer
// Purpose: scan state encoding, digit count and all-off segment codes for both polarities.
// Ports: none (package).
package seg_scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_OFF_AL = 7'h7F;
    localparam logic [6:0] SEG_OFF_AH = 7'h00;

endpackage

// File: rtl/seg_tick_counter.sv
// rtl/seg_tick_counter.sv - per-digit slot counter with wrap flag
// Purpose: counts 0..CLK_DIV-1 while run=1, returns to 0 when run=0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : 1 = count, 0 = hold at zero
//   cnt_next   : value the counter takes at the next rising edge
//   wrap       : counter is at CLK_DIV-1 and will wrap at the next edge
module seg_tick_counter #(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [CNT_W-1:0] cnt_next,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        wrap = run && (cnt_q == LAST);
        if (!run || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        cnt_next = cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - four-digit seven-segment scan multiplexer
// Purpose: time-multiplexes four segment patterns onto a shared bus with a
// blanking gap at the start of each digit slot; patterns are double-buffered
// so a frame never mixes old and new data.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   seg0_in..seg3_in    : patterns {g..a}, 1 = lit, for digits 0..3
//   load                : strobe, captures all four patterns into the pending buffer
//   en                  : 1 = scanning, 0 = dark
//   an                  : digit enables, active-low
//   seg                 : segment bus, polarity set by SEG_ACTIVE_LOW
//   frame_done          : one-cycle pulse after the digit-3 slot ends
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg0_in,
    input  logic [6:0] seg1_in,
    input  logic [6:0] seg2_in,
    input  logic [6:0] seg3_in,
    input  logic       load,
    input  logic       en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int               CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
    localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;

    logic [CNT_W-1:0] cnt_next;
    logic             wrap;
    logic             run;
    logic             frame_wrap;

    // ready_q holds scanning off for the first edge after reset release
    logic                       ready_q, ready_d;
    state_e                     state_q, state_d;
    logic [1:0]                 digit_q, digit_d;
    logic [DIGITS-1:0][6:0]     pending_q, pending_d;
    logic [DIGITS-1:0][6:0]     shadow_q, shadow_d;
    logic [3:0]                 an_q, an_d;
    logic [6:0]                 seg_q, seg_d;
    logic                       frame_done_q, frame_done_d;

    seg_tick_counter #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .cnt_next (cnt_next),
        .wrap     (wrap)
    );

    always_comb begin
        ready_d    = 1'b1;
        run        = en && ready_q;
        frame_wrap = wrap && (digit_q == 2'd3);

        digit_d = run ? (wrap ? digit_q + 2'd1 : digit_q) : 2'd0;

        // Outputs are registered from next-state values so they change on the
        // same edge as the counter reaches the relevant slot position.
        case (state_q)
            IDLE:    state_d = (cnt_next >= BLANK_C) ? SHOW : BLANK;
            BLANK:   state_d = (cnt_next >= BLANK_C) ? SHOW : BLANK;
            SHOW:    state_d = wrap ? BLANK : SHOW;
            default: state_d = IDLE;
        endcase
        if (!run) begin
            state_d = IDLE;
        end

        pending_d = load ? {seg3_in, seg2_in, seg1_in, seg0_in} : pending_q;
        // pending_d already carries a coincident load straight into shadow
        shadow_d  = frame_wrap ? pending_d : shadow_q;

        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        if (state_d == SHOW) begin
            an_d[digit_d] = 1'b0;
            seg_d         = SEG_ACTIVE_LOW ? ~shadow_d[digit_d] : shadow_d[digit_d];
        end

        frame_done_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            state_q      <= IDLE;
            digit_q      <= 2'd0;
            pending_q    <= '0;
            shadow_q     <= '0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            state_q      <= state_d;
            digit_q      <= digit_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg0_in, seg1_in, seg2_in, seg3_in;
    logic       load;
    logic       en;
    logic [3:0] an, an_ah;
    logic [6:0] seg, seg_ah;
    logic       frame_done, fd_ah;

    int n_pass  = 0;
    int n_total = 0;

    seg_scan_mux #(.CLK_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .seg0_in(seg0_in), .seg1_in(seg1_in), .seg2_in(seg2_in), .seg3_in(seg3_in),
        .load(load), .en(en), .an(an), .seg(seg), .frame_done(frame_done)
    );

    seg_scan_mux #(.CLK_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .rst_n(rst_n),
        .seg0_in(seg0_in), .seg1_in(seg1_in), .seg2_in(seg2_in), .seg3_in(seg3_in),
        .load(load), .en(en), .an(an_ah), .seg(seg_ah), .frame_done(fd_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       load;
        logic [6:0] p0, p1, p2, p3;
        int         adv;
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] seg_ah;
        logic       fd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic l, logic [6:0] p0, logic [6:0] p1,
                                logic [6:0] p2, logic [6:0] p3, int adv,
                                logic [3:0] a, logic [6:0] s, logic [6:0] sh, logic f);
        vec_t v;
        v.en = e; v.load = l; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
        v.adv = adv; v.an = a; v.seg = s; v.seg_ah = sh; v.fd = f;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, logic [3:0] a, logic [6:0] s, logic [6:0] sh, logic f);
        chk({tag, " an"},         32'(an),         32'(a));
        chk({tag, " seg"},        32'(seg),        32'(s));
        chk({tag, " seg_ah"},     32'(seg_ah),     32'(sh));
        chk({tag, " an_ah"},      32'(an_ah),      32'(a));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(f));
    endtask

    initial begin
        // k = edges since en was first sampled high; slot = 8 edges, blank = cnt 0..1
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hF, 7'h7F, 7'h00, 0)); // k1
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hE, 7'h7F, 7'h00, 0)); // k2
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5, 4'hE, 7'h7F, 7'h00, 0)); // k7
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hF, 7'h7F, 7'h00, 0)); // k8
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 4'hD, 7'h7F, 7'h00, 0)); // k10
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 4'hB, 7'h7F, 7'h00, 0)); // k18
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 4'h7, 7'h7F, 7'h00, 0)); // k26
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5, 4'h7, 7'h7F, 7'h00, 0)); // k31
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hF, 7'h7F, 7'h00, 1)); // k32
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hF, 7'h7F, 7'h00, 0)); // k33
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hE, 7'h7F, 7'h00, 0)); // k34
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 4'hE, 7'h7F, 7'h00, 0)); // k36
        vecs.push_back(mk(1, 1, 7'h3F, 7'h06, 7'h5B, 7'h4F, 6, 4'hD, 7'h7F, 7'h00, 0)); // k42 mid-frame load
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16, 4'h7, 7'h7F, 7'h00, 0)); // k58
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 6, 4'hF, 7'h7F, 7'h00, 1));  // k64
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 4'hE, 7'h40, 7'h3F, 0));  // k66
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 4'hD, 7'h79, 7'h06, 0));  // k74
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 4'hB, 7'h24, 7'h5B, 0));  // k82
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 4'h7, 7'h30, 7'h4F, 0));  // k90
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5, 4'h7, 7'h30, 7'h4F, 0));  // k95 cnt7 digit3
        vecs.push_back(mk(1, 1, 7'h06, 7'h06, 7'h06, 7'h06, 1, 4'hF, 7'h7F, 7'h00, 1)); // k96 load on wrap
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 4'hE, 7'h79, 7'h06, 0));  // k98
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 4'hD, 7'h79, 7'h06, 0));  // k106
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 11, 4'hB, 7'h79, 7'h06, 0)); // k117 cnt5 digit2
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 7'h7F, 7'h00, 0));  // en dropped
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 4'hF, 7'h7F, 7'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hF, 7'h7F, 7'h00, 0));  // re-enable k'1
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hE, 7'h79, 7'h06, 0));  // k'2 shadow kept
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 4'hD, 7'h79, 7'h06, 0));  // k'10

        rst_n = 1'b0;
        en = 1'b0; load = 1'b0;
        seg0_in = '0; seg1_in = '0; seg2_in = '0; seg3_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'hF, 7'h7F, 7'h00, 1'b0);
        #2 rst_n = 1'b1;
        repeat (3) step();
        chk_all("idle", 4'hF, 7'h7F, 7'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            en      = vecs[i].en;
            load    = vecs[i].load;
            seg0_in = vecs[i].p0;
            seg1_in = vecs[i].p1;
            seg2_in = vecs[i].p2;
            seg3_in = vecs[i].p3;
            for (int c = 0; c < vecs[i].adv; c++) begin
                step();
                load = 1'b0;
            end
            chk_all($sformatf("row%0d", i), vecs[i].an, vecs[i].seg, vecs[i].seg_ah, vecs[i].fd);
        end

        // Reset pulsed between edges while digit 1 is showing
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'hF, 7'h7F, 7'h00, 1'b0);
        #2 rst_n = 1'b1;
        step();
        chk_all("rst_rel_e1", 4'hF, 7'h7F, 7'h00, 1'b0);
        step();
        chk_all("rst_rel_e2", 4'hF, 7'h7F, 7'h00, 1'b0);
        step();
        chk_all("rst_rel_e3", 4'hE, 7'h7F, 7'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
